ifu_fetch: RTL

//  Instruction fetch unit directly upstream of the RV32E core. Takes the core's pc, runs
//  a req/gnt/rvalid transaction on the instruction-memory port, and holds the fetched

---
 rtl/ifu_fetch_pkg.sv | 20 ++
 rtl/ifu_timeout_cnt.sv | 32 +++
 rtl/ifu_fetch.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/ifu_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_fetch_pkg;

    localparam int          REG_BUS     = 32;
    localparam logic [31:0] RST_VAL     = 32'h0000_0000;
    localparam logic [31:0] INST_NOP    = 32'h0000_0013;
    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

    typedef enum logic [1:0] {
        IFU_IDLE = 2'd0,
        IFU_REQ  = 2'd1,
        IFU_WAIT = 2'd2,
        IFU_HALT = 2'd3
    } ifu_state_t;

    function automatic logic is_word_aligned(input logic [REG_BUS-1:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/ifu_timeout_cnt.sv
// Saturating no-response timer for one fetch transaction.
// o_expired flags the cycle whose increment reaches LIMIT.
module ifu_timeout_cnt #(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    localparam int W = $clog2(LIMIT + 1);
    localparam logic [W-1:0] LIMIT_W  = W'(LIMIT);
    localparam logic [W-1:0] LIMIT_M1 = W'(LIMIT - 1);

    logic [W-1:0] r_cnt;

    // Count cycles while enabled, holding at LIMIT instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != LIMIT_W)) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign o_expired = i_en && !i_clr && (r_cnt >= LIMIT_M1);

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: one req/gnt/rvalid transaction per accepted fetch,
// fetched word held on o_inst. Faults park the unit in HALT with ebreak on o_inst.
module ifu_fetch
    import ifu_fetch_pkg::*;
#(
    parameter int          TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_INST       = INST_EBREAK,
    parameter logic [31:0] RST_INST       = INST_NOP
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] i_pc,
    input  logic        i_fetch_start,
    output logic [31:0] o_inst,
    output logic        o_inst_valid,
    output logic        o_busy,
    output logic        o_fault,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_gnt,
    input  logic        i_imem_rvalid,
    input  logic [31:0] i_imem_rdata,
    input  logic        i_imem_err
);

    ifu_state_t  r_state, w_state_nxt;
    logic [31:0] r_inst, w_inst_nxt;
    logic        r_inst_valid, w_inst_valid_nxt;
    logic        r_busy, w_busy_nxt;
    logic        r_fault, w_fault_nxt;
    logic        r_req, w_req_nxt;
    logic [31:0] r_addr, w_addr_nxt;

    logic        w_cnt_clr;
    logic        w_cnt_en;
    logic        w_expired;
    logic        w_go_halt;

    ifu_timeout_cnt #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk       (clk),
        .rst       (rst),
        .i_clr     (w_cnt_clr),
        .i_en      (w_cnt_en),
        .o_expired (w_expired)
    );

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IFU_IDLE;
            r_inst       <= RST_INST;
            r_inst_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_fault      <= 1'b0;
            r_req        <= 1'b0;
            r_addr       <= RST_VAL;
        end else begin
            r_state      <= w_state_nxt;
            r_inst       <= w_inst_nxt;
            r_inst_valid <= w_inst_valid_nxt;
            r_busy       <= w_busy_nxt;
            r_fault      <= w_fault_nxt;
            r_req        <= w_req_nxt;
            r_addr       <= w_addr_nxt;
        end
    end

    // Next-state and next-output decode; HALT entry overrides whatever the state chose.
    always_comb begin
        w_state_nxt      = r_state;
        w_inst_nxt       = r_inst;
        w_inst_valid_nxt = r_inst_valid;
        w_busy_nxt       = r_busy;
        w_fault_nxt      = r_fault;
        w_req_nxt        = r_req;
        w_addr_nxt       = r_addr;
        w_cnt_clr        = 1'b0;
        w_cnt_en         = 1'b0;
        w_go_halt        = 1'b0;

        case (r_state)
            IFU_IDLE: begin
                if (i_fetch_start) begin
                    w_inst_valid_nxt = 1'b0;
                    w_busy_nxt       = 1'b1;
                    if (!is_word_aligned(i_pc)) begin
                        w_go_halt = 1'b1;
                    end else begin
                        w_state_nxt = IFU_REQ;
                        w_req_nxt   = 1'b1;
                        w_addr_nxt  = i_pc;
                        w_cnt_clr   = 1'b1;
                    end
                end
            end
            IFU_REQ: begin
                w_cnt_en = 1'b1;
                if (i_imem_gnt) begin
                    w_req_nxt = 1'b0;
                    // Same-cycle rvalid completes the fetch without visiting WAIT.
                    if (i_imem_rvalid) begin
                        if (i_imem_err) begin
                            w_go_halt = 1'b1;
                        end else begin
                            w_state_nxt      = IFU_IDLE;
                            w_inst_nxt       = i_imem_rdata;
                            w_inst_valid_nxt = 1'b1;
                            w_busy_nxt       = 1'b0;
                        end
                    end else begin
                        w_state_nxt = IFU_WAIT;
                    end
                end else if (w_expired) begin
                    w_go_halt = 1'b1;
                end
            end
            IFU_WAIT: begin
                w_cnt_en = 1'b1;
                if (i_imem_rvalid) begin
                    if (i_imem_err) begin
                        w_go_halt = 1'b1;
                    end else begin
                        w_state_nxt      = IFU_IDLE;
                        w_inst_nxt       = i_imem_rdata;
                        w_inst_valid_nxt = 1'b1;
                        w_busy_nxt       = 1'b0;
                    end
                end else if (w_expired) begin
                    w_go_halt = 1'b1;
                end
            end
            IFU_HALT: begin
                w_state_nxt = IFU_HALT;
            end
            default: begin
                w_state_nxt = IFU_IDLE;
            end
        endcase

        if (w_go_halt) begin
            w_state_nxt      = IFU_HALT;
            w_inst_nxt       = ERR_INST;
            w_inst_valid_nxt = 1'b1;
            w_busy_nxt       = 1'b0;
            w_fault_nxt      = 1'b1;
            w_req_nxt        = 1'b0;
        end
    end

    assign o_inst       = r_inst;
    assign o_inst_valid = r_inst_valid;
    assign o_busy       = r_busy;
    assign o_fault      = r_fault;
    assign o_imem_req   = r_req;
    assign o_imem_addr  = r_addr;

endmodule
